// File: rtl/deco_nx2n_scan_pkg.sv
// ----------------------------------------------------------------------------
// deco_pkg
// Shared types and helpers for the deco_nx2n_scan decoder.
//   state_t : FSM encoding (IDLE / DIRECT / SCAN)
//   out_w   : output vector width for a given select width (2**n_sel)
//   onehot  : one-hot vector with bit idx set (up to 64 bits, i.e. N_SEL <= 6)
// ----------------------------------------------------------------------------
package deco_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic int out_w(input int n_sel);
        return 1 << n_sel;
    endfunction

    function automatic logic [63:0] onehot(input int unsigned idx);
        return 64'd1 << idx;
    endfunction

endpackage

// File: rtl/deco_nx2n_scan_if.sv
// ----------------------------------------------------------------------------
// deco_nx2n_scan_if
// Select handshake and decoded-output bundle of deco_nx2n_scan.
//   en, mode, sel, sel_vld         : controller -> decoder
//   sel_rdy, d, d_vld, scan_wrap,
//   busy                           : decoder -> consumer
// Modports: master (controller side), slave (decoder side).
// ----------------------------------------------------------------------------
interface deco_nx2n_scan_if
    import deco_pkg::*;
#(
    parameter int N_SEL = 3
);
    localparam int W = out_w(N_SEL);

    logic             en;
    logic             mode;
    logic [N_SEL-1:0] sel;
    logic             sel_vld;
    logic             sel_rdy;
    logic [W-1:0]     d;
    logic             d_vld;
    logic             scan_wrap;
    logic             busy;

    modport master (
        output en, mode, sel, sel_vld,
        input  sel_rdy, d, d_vld, scan_wrap, busy
    );

    modport slave (
        input  en, mode, sel, sel_vld,
        output sel_rdy, d, d_vld, scan_wrap, busy
    );

endinterface

// File: rtl/deco_nx2n_scan_dwell_cnt.sv
// ----------------------------------------------------------------------------
// deco_dwell_cnt
// Dwell counter: counts 0..HOLD_CYCLES-1 while en_i is high and wraps.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (has priority over en_i)
//   en_i       : count enable
//   tc_o       : high while enabled and sitting on the last count
// ----------------------------------------------------------------------------
module deco_dwell_cnt #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    // HOLD_CYCLES = 1 still needs a one-bit register so the port list is legal.
    localparam int             CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (tc_o)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/deco_nx2n_scan.sv
// ----------------------------------------------------------------------------
// deco_nx2n_scan
// Registered N-to-2^N one-hot decoder with a direct (handshaken) mode and an
// autonomous scan mode walking a single one across all outputs, each position
// held HOLD_CYCLES clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : deco_nx2n_scan_if.slave
//                en/mode/sel/sel_vld in; sel_rdy/d/d_vld/scan_wrap/busy out
// Build option: DECO_ACTIVE_LOW_EN drives d inverted (inactive = all ones).
// ----------------------------------------------------------------------------
module deco_nx2n_scan
    import deco_pkg::*;
#(
    parameter int N_SEL       = 3,
    parameter int HOLD_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    deco_nx2n_scan_if.slave bus
);
    localparam int               W       = out_w(N_SEL);
    localparam logic [N_SEL-1:0] IDX_MAX = '1;

    // d is stored already in output polarity; POL is XORed onto every
    // active-high value so the register itself is the output.
`ifdef DECO_ACTIVE_LOW_EN
    localparam logic [W-1:0] POL = '1;
`else
    localparam logic [W-1:0] POL = '0;
`endif

    state_t           state_q, state_d;
    logic [W-1:0]     d_q, d_d;
    logic             d_vld_q, d_vld_d;
    logic             wrap_q, wrap_d;
    logic [N_SEL-1:0] idx_q, idx_d;
    logic [N_SEL-1:0] idx_inc;
    logic             cnt_clr;
    logic             cnt_tc;
    logic             sel_rdy;
    logic             hs;

    // Ready depends only on registered state and the level controls.
    assign sel_rdy = bus.en & ~bus.mode & (state_q != SCAN);
    assign hs      = bus.sel_vld & sel_rdy;
    assign idx_inc = idx_q + 1'b1;

    deco_dwell_cnt #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr | (state_q != SCAN)),
        .en_i  (state_q == SCAN),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        d_vld_d = d_vld_q;
        wrap_d  = 1'b0;
        idx_d   = idx_q;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE, DIRECT: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    d_d     = POL;
                    d_vld_d = 1'b0;
                end else if (bus.mode) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    d_d     = W'(onehot(0)) ^ POL;
                    d_vld_d = 1'b1;
                end else if (hs) begin
                    state_d = DIRECT;
                    d_d     = W'(onehot(int'(bus.sel))) ^ POL;
                    d_vld_d = 1'b1;
                end
            end
            SCAN: begin
                if (!bus.en || !bus.mode) begin
                    state_d = bus.en ? DIRECT : IDLE;
                    d_d     = POL;
                    d_vld_d = 1'b0;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    // Index wraps naturally in N_SEL bits.
                    idx_d   = idx_inc;
                    d_d     = W'(onehot(int'(idx_inc))) ^ POL;
                    wrap_d  = (idx_q == IDX_MAX);
                end
            end
            default: begin
                state_d = IDLE;
                d_d     = POL;
                d_vld_d = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= POL;
            d_vld_q <= 1'b0;
            wrap_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            d_vld_q <= d_vld_d;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.sel_rdy   = sel_rdy;
    assign bus.d         = d_q;
    assign bus.d_vld     = d_vld_q;
    assign bus.scan_wrap = wrap_q;
    assign bus.busy      = (state_q == SCAN);

endmodule

// File: tb/tb_deco_nx2n_scan.sv
// ----------------------------------------------------------------------------
// tb_deco_nx2n_scan
// Directed bench for deco_nx2n_scan with N_SEL = 3, HOLD_CYCLES = 4.
// Honours DECO_ACTIVE_LOW_EN by inverting expected d values.
// ----------------------------------------------------------------------------
module tb_deco_nx2n_scan;

    localparam int N_SEL = 3;
    localparam int HOLD  = 4;

`ifdef DECO_ACTIVE_LOW_EN
    localparam logic [7:0] POL = 8'hFF;
`else
    localparam logic [7:0] POL = 8'h00;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    deco_nx2n_scan_if #(.N_SEL(N_SEL)) bus ();

    deco_nx2n_scan #(
        .N_SEL       (N_SEL),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.mode    = 1'b0;
        bus.sel     = '0;
        bus.sel_vld = 1'b0;
        #3;
        n_cmp++;
        if (bus.d !== (8'h00 ^ POL) || bus.d_vld !== 1'b0 || bus.busy !== 1'b0 ||
            bus.sel_rdy !== 1'b0 || bus.scan_wrap !== 1'b0) begin
            n_err++;
            $display("FAIL reset d=%h vld=%b busy=%b rdy=%b wrap=%b exp d=%h others 0",
                     bus.d, bus.d_vld, bus.busy, bus.sel_rdy, bus.scan_wrap, 8'h00 ^ POL);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        $display("reset: d=%h vld=%b busy=%b", bus.d, bus.d_vld, bus.busy);
    endtask

    task automatic test_direct_sweep();
        logic [7:0] exp_d;
        bus.en      = 1'b1;
        bus.mode    = 1'b0;
        bus.sel_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.sel = 3'(i);
            step();
            exp_d = (8'h01 << i) ^ POL;
            n_cmp++;
            if (bus.d !== exp_d || bus.d_vld !== 1'b1 || bus.sel_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL sweep sel=%0d d=%h vld=%b rdy=%b exp d=%h vld=1 rdy=1",
                         i, bus.d, bus.d_vld, bus.sel_rdy, exp_d);
            end
            $display("sweep: sel=%0d d=%h", i, bus.d);
        end
    endtask

    task automatic test_hold_disable();
        bus.sel = 3'd5;
        step();
        bus.sel_vld = 1'b0;
        bus.sel     = 3'd1;
        step();
        step();
        n_cmp++;
        if (bus.d !== (8'h20 ^ POL) || bus.d_vld !== 1'b1) begin
            n_err++;
            $display("FAIL hold d=%h vld=%b exp d=%h vld=1", bus.d, bus.d_vld, 8'h20 ^ POL);
        end
        $display("hold: d=%h", bus.d);
        bus.en = 1'b0;
        step();
        n_cmp++;
        if (bus.d !== (8'h00 ^ POL) || bus.d_vld !== 1'b0) begin
            n_err++;
            $display("FAIL disable d=%h vld=%b exp d=%h vld=0", bus.d, bus.d_vld, 8'h00 ^ POL);
        end
        bus.sel_vld = 1'b1;
        bus.sel     = 3'd3;
        #1;
        n_cmp++;
        if (bus.sel_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL disabled_rdy rdy=%b exp 0", bus.sel_rdy);
        end
        step();
        n_cmp++;
        if (bus.d !== (8'h00 ^ POL) || bus.d_vld !== 1'b0) begin
            n_err++;
            $display("FAIL disabled_noupd d=%h vld=%b exp d=%h vld=0", bus.d, bus.d_vld, 8'h00 ^ POL);
        end
        $display("disable: d=%h vld=%b rdy=%b", bus.d, bus.d_vld, bus.sel_rdy);
        bus.sel_vld = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] exp_d;
        int         bad;
        bus.en   = 1'b1;
        bus.mode = 1'b1;
        step();
        for (int p = 0; p < 8; p++) begin
            bad   = 0;
            exp_d = (8'h01 << p) ^ POL;
            for (int k = 0; k < HOLD; k++) begin
                n_cmp++;
                if (bus.d !== exp_d || bus.d_vld !== 1'b1 || bus.busy !== 1'b1 ||
                    bus.sel_rdy !== 1'b0 || bus.scan_wrap !== 1'b0) begin
                    n_err++;
                    bad++;
                    $display("FAIL scan pos=%0d k=%0d d=%h vld=%b busy=%b rdy=%b wrap=%b exp d=%h 1 1 0 0",
                             p, k, bus.d, bus.d_vld, bus.busy, bus.sel_rdy, bus.scan_wrap, exp_d);
                end
                step();
            end
            $display("scan: pos=%0d held %0d cycles, errors=%0d", p, HOLD, bad);
        end
        n_cmp++;
        if (bus.d !== (8'h01 ^ POL) || bus.scan_wrap !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL scan_wrap d=%h wrap=%b busy=%b exp d=%h wrap=1 busy=1",
                     bus.d, bus.scan_wrap, bus.busy, 8'h01 ^ POL);
        end
        step();
        n_cmp++;
        if (bus.d !== (8'h01 ^ POL) || bus.scan_wrap !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pulse d=%h wrap=%b exp d=%h wrap=0", bus.d, bus.scan_wrap, 8'h01 ^ POL);
        end
        $display("scan: wrap pulse checked, d=%h", bus.d);
    endtask

    task automatic test_mid_scan_exit();
        bus.en = 1'b0;
        step();
        bus.en   = 1'b1;
        bus.mode = 1'b1;
        step();
        for (int i = 0; i < 3 * HOLD; i++) step();
        n_cmp++;
        if (bus.d !== (8'h08 ^ POL)) begin
            n_err++;
            $display("FAIL midscan_pos d=%h exp %h", bus.d, 8'h08 ^ POL);
        end
        bus.mode = 1'b0;
        step();
        n_cmp++;
        if (bus.d !== (8'h00 ^ POL) || bus.d_vld !== 1'b0 || bus.sel_rdy !== 1'b1 ||
            bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL scan_exit d=%h vld=%b rdy=%b busy=%b exp d=%h vld=0 rdy=1 busy=0",
                     bus.d, bus.d_vld, bus.sel_rdy, bus.busy, 8'h00 ^ POL);
        end
        bus.sel     = 3'd2;
        bus.sel_vld = 1'b1;
        step();
        n_cmp++;
        if (bus.d !== (8'h04 ^ POL) || bus.d_vld !== 1'b1) begin
            n_err++;
            $display("FAIL exit_hs d=%h vld=%b exp d=%h vld=1", bus.d, bus.d_vld, 8'h04 ^ POL);
        end
        bus.sel_vld = 1'b0;
        bus.mode    = 1'b1;
        step();
        n_cmp++;
        if (bus.d !== (8'h01 ^ POL) || bus.busy !== 1'b1 || bus.scan_wrap !== 1'b0) begin
            n_err++;
            $display("FAIL rescan d=%h busy=%b wrap=%b exp d=%h busy=1 wrap=0",
                     bus.d, bus.busy, bus.scan_wrap, 8'h01 ^ POL);
        end
        $display("midscan exit/re-entry: d=%h busy=%b", bus.d, bus.busy);
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < HOLD + 1; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.d !== (8'h00 ^ POL) || bus.d_vld !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset d=%h vld=%b busy=%b exp d=%h vld=0 busy=0",
                     bus.d, bus.d_vld, bus.busy, 8'h00 ^ POL);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (bus.d !== (8'h01 ^ POL) || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart d=%h busy=%b exp d=%h busy=1", bus.d, bus.busy, 8'h01 ^ POL);
        end
        $display("reset mid-scan: restart d=%h", bus.d);
    endtask

    task automatic test_direct_sel3();
        bus.en      = 1'b1;
        bus.mode    = 1'b0;
        step();
        bus.sel     = 3'd3;
        bus.sel_vld = 1'b1;
        step();
        bus.sel_vld = 1'b0;
        n_cmp++;
        if (bus.d !== (8'h08 ^ POL) || bus.d_vld !== 1'b1) begin
            n_err++;
            $display("FAIL direct_sel3 d=%h vld=%b exp d=%h vld=1", bus.d, bus.d_vld, 8'h08 ^ POL);
        end
        $display("direct sel=3: d=%h", bus.d);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_direct_sweep();
        test_hold_disable();
        test_scan();
        test_mid_scan_exit();
        test_reset_mid_scan();
        test_direct_sel3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
